ats21_alarm_event_queue: RTL and testbench
==========================================

Name: ats21_alarm_event_queue

Overview:
- Downstream consumer of the ATS21 `data[23:0]` alarm/timer "finished" outputs. Each ATS21 alarm bit is a level that stays high for about 2 cycles.
- Detects rising edges on those bits and converts them into discrete events tagged {alarm id, timestamp}.
- Buffers the events in a FIFO and presents them to a host/interrupt controller over a valid/ready interface, with masking and overflow reporting.

Parameters:
- NUM_ALARMS, 24, number of alarm inputs; must match ATS21.
- FIFO_DEPTH, 8, event entries; power of 2, at least 2.
- TS_WIDTH, 16, width of the free-running timestamp counter.

Ports:
- clk_1x  in  1  ATS21 1x reference clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- alarm_in  in  NUM_ALARMS  ATS21 data outputs; bit i = alarm i finished.
- mask_wr  in  1  write strobe for the mask register.
- mask_data  in  NUM_ALARMS  new mask value; 1 = ignore that alarm.
- evt_ready  in  1  consumer accepts the head event.
- ovf_clr  in  1  clears the overflow flag.
- evt_valid  out  1  FIFO non-empty.
- evt_id  out  $clog2(NUM_ALARMS)  alarm index of the head event.
- evt_ts  out  TS_WIDTH  timestamp of the head event.
- evt_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: at least one event was lost.
- irq  out  1  evt_valid OR overflow.

Behaviour:
- Reset values:
  - alarm_q, pending, mask, FIFO pointers, ts counter and overflow all 0.
  - evt_valid=0, evt_count=0, evt_id=0, evt_ts=0, irq=0.
  - Reset mid-operation discards all queued and pending events immediately.
- Timestamp: ts_cnt increments every clk_1x edge and wraps 2^TS_WIDTH-1 -> 0 with no flag.
- Edge detect:
  - alarm_q <= alarm_in every edge.
  - rise = alarm_in & ~alarm_q & ~mask.
  - Because alarm_q resets to 0, a bit already high at reset release produces an event.
- Pending vector, per bit i, evaluated each edge:
  - if rise[i]: pending[i] <= 1.
  - If rise[i] and pending[i] is already 1 and not being pushed this cycle, the event is lost: overflow <= 1.
  - if pushed[i] and no new rise[i]: pending[i] <= 0. A push and a new rise on the same bit in the same cycle leave pending=1, with no overflow.
  - mask_wr: mask <= mask_data, and pending bits newly masked are cleared in the same edge.
- Push:
  - When pending != 0 and the FIFO is not full (or is full but popping this cycle), write the lowest-index pending bit as {id, ts_cnt} on this edge.
  - At most one push per cycle; other pending bits wait.
- Pop: when evt_valid && evt_ready, the head advances on this edge.
- Simultaneous push and pop:
  - Both occur; evt_count is unchanged.
  - If full, the popped slot is reused this edge.
- Latency:
  - alarm_in rises before edge E0 -> pending set at E0 -> FIFO write at E1 -> evt_valid=1 after E1.
  - That is 2 edges with an empty FIFO and no lower-index pending bits.
- Output: first-word fall-through. evt_id and evt_ts are driven from the head entry and are stable while evt_valid && !evt_ready.
- FIFO full:
  - No push; events stay in pending; only a repeat rise on a still-pending bit sets overflow.
  - The FIFO never overwrites.
- overflow: set as above; cleared by ovf_clr unless a new loss occurs in the same cycle, in which case set wins.
- evt_valid, evt_count and irq are registered-state derived: no combinational path from evt_ready or alarm_in to them.

Decomposition:
- ats21_pkg holds:
  - NUM_ALARMS, ALARM_ID_W = $clog2(NUM_ALARMS), TS_WIDTH.
  - typedef struct packed {logic [ALARM_ID_W-1:0] id; logic [TS_WIDTH-1:0] ts;} alarm_evt_t.
- Sub-module ats21_evt_fifo: synchronous FWFT FIFO of alarm_evt_t with push, pop, full, empty, count.
- Edge detect, pending, priority encoder, mask, ts counter and overflow stay in the top.

Test Plan:
- Reset, then a 2-cycle pulse on alarm_in[5] with evt_ready=0:
  - evt_valid=1 exactly 2 edges after the rise; evt_id=5; evt_count=1.
  - A single event only, not two for the 2-cycle level.
- alarm_in[3], [9] and [17] rise in the same cycle, evt_ready=1:
  - Three events in order id 3, 9, 17 on consecutive cycles.
  - evt_ts values increase by 1.
- mask_data=24'h000020, then pulse bit 5 and bit 6:
  - Only id 6 is queued.
  - Writing mask=0 afterwards does not resurrect bit 5.
- evt_ready=0, pulse 9 distinct alarms (ids 0..8):
  - FIFO fills with ids 0..7, evt_count=8; id 8 is pending and overflow=0.
  - Pulse id 8 again: overflow=1 and irq=1.
  - Pop one: id 8 is written the same edge and count stays 8.
- ovf_clr asserted in the same cycle as a new loss -> overflow stays 1. Next cycle, ovf_clr alone -> overflow=0.
- Queue 3 events, assert reset asynchronously mid-cycle:
  - evt_valid and evt_count drop to 0 immediately.
  - alarm_in[2] held high across reset release yields one event, id 2.

Source files
------------

// File: rtl/ats21_pkg.sv
// Shared ATS21 alarm widths, the queued event record and a priority helper.
package ats21_pkg;

    localparam int NUM_ALARMS = 24;
    localparam int ALARM_ID_W = $clog2(NUM_ALARMS);
    localparam int TS_WIDTH   = 16;

    typedef struct packed {
        logic [ALARM_ID_W-1:0] id;
        logic [TS_WIDTH-1:0]   ts;
    } alarm_evt_t;

    // Scanning from the top down leaves the lowest set index as the result.
    function automatic logic [ALARM_ID_W-1:0] lowestSet(input logic [NUM_ALARMS-1:0] vec);
        logic [ALARM_ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ALARM_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ats21_evt_fifo.sv
// First-word fall-through event FIFO; a push while full is only taken alongside a pop.
module ats21_evt_fifo
    import ats21_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk_1x,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [$bits(alarm_evt_t)-1:0] wrData_i,
    output logic [$bits(alarm_evt_t)-1:0] rdData_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wrPtr_q, wrPtr_d;
    logic [PTR_W:0] rdPtr_q, rdPtr_d;
    logic [$bits(alarm_evt_t)-1:0] mem_q [DEPTH];
    logic doPush;
    logic doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        count_o  = wrPtr_q - rdPtr_q;
        empty_o  = (wrPtr_q == rdPtr_q);
        full_o   = (count_o == (PTR_W + 1)'(DEPTH));
        doPop    = pop_i && !empty_o;
        doPush   = push_i && (!full_o || doPop);
        wrPtr_d  = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d  = doPop ? rdPtr_q + 1'b1 : rdPtr_q;
        rdData_o = empty_o ? '0 : mem_q[rdPtr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_1x) begin
        if (doPush) begin
            mem_q[wrPtr_q[PTR_W-1:0]] <= wrData_i;
        end
    end

endmodule

// File: rtl/ats21_alarm_event_queue.sv
// Turns ATS21 alarm level pulses into timestamped events queued for a host.
module ats21_alarm_event_queue
    import ats21_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_1x,
    input  logic                        reset,
    input  logic [NUM_ALARMS-1:0]       alarm_in,
    input  logic                        mask_wr,
    input  logic [NUM_ALARMS-1:0]       mask_data,
    input  logic                        evt_ready,
    input  logic                        ovf_clr,
    output logic                        evt_valid,
    output logic [ALARM_ID_W-1:0]       evt_id,
    output logic [TS_WIDTH-1:0]         evt_ts,
    output logic [$clog2(FIFO_DEPTH):0] evt_count,
    output logic                        overflow,
    output logic                        irq
);

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [NUM_ALARMS-1:0] alarm_q;
    logic [NUM_ALARMS-1:0] mask_q, mask_d;
    logic [NUM_ALARMS-1:0] pending_q, pending_d;
    logic                  overflow_q, overflow_d;

    logic [NUM_ALARMS-1:0] rise;
    logic [NUM_ALARMS-1:0] pushed;
    logic [ALARM_ID_W-1:0] pushId;
    logic                  pushEn;
    logic                  popEn;
    logic                  lost;
    logic                  fifoFull;
    logic                  fifoEmpty;
    alarm_evt_t            pushEvt;
    alarm_evt_t            headEvt;
    logic [$bits(alarm_evt_t)-1:0] headRaw;

    // A rise on a bit that is still pending and not leaving this edge is a lost event.
    always_comb begin
        rise       = alarm_in & ~alarm_q & ~mask_q;
        popEn      = !fifoEmpty && evt_ready;
        pushEn     = (|pending_q) && (!fifoFull || popEn);
        pushId     = lowestSet(pending_q);
        pushed     = pushEn ? (NUM_ALARMS'(1) << pushId) : '0;
        lost       = |(rise & pending_q & ~pushed);
        pending_d  = (pending_q & ~pushed) | rise;
        mask_d     = mask_q;
        if (mask_wr) begin
            mask_d    = mask_data;
            pending_d = pending_d & ~mask_data;
        end
        overflow_d = lost | (overflow_q & ~ovf_clr);
        ts_d       = ts_q + 1'b1;
        pushEvt.id = pushId;
        pushEvt.ts = ts_q;
    end

    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            alarm_q    <= '0;
            mask_q     <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            alarm_q    <= alarm_in;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    ats21_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_1x   (clk_1x),
        .reset    (reset),
        .push_i   (pushEn),
        .pop_i    (popEn),
        .wrData_i (pushEvt),
        .rdData_o (headRaw),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty),
        .count_o  (evt_count)
    );

    always_comb begin
        headEvt   = alarm_evt_t'(headRaw);
        evt_valid = !fifoEmpty;
        evt_id    = headEvt.id;
        evt_ts    = headEvt.ts;
        overflow  = overflow_q;
        irq       = !fifoEmpty || overflow_q;
    end

endmodule

// File: tb/tb_ats21_alarm_event_queue.sv
// Directed bench for the ATS21 alarm event queue with hand-computed expectations.
module tb_ats21_alarm_event_queue;

    logic        clk_1x = 1'b0;
    logic        reset;
    logic [23:0] alarm_in;
    logic        mask_wr;
    logic [23:0] mask_data;
    logic        evt_ready;
    logic        ovf_clr;
    logic        evt_valid;
    logic [4:0]  evt_id;
    logic [15:0] evt_ts;
    logic [3:0]  evt_count;
    logic        overflow;
    logic        irq;

    int          numAsserts = 0;
    int          numFails   = 0;
    logic [15:0] ts0;

    always #5 clk_1x = ~clk_1x;

    ats21_alarm_event_queue #(
        .FIFO_DEPTH(8)
    ) dut (
        .clk_1x    (clk_1x),
        .reset     (reset),
        .alarm_in  (alarm_in),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ts    (evt_ts),
        .evt_count (evt_count),
        .overflow  (overflow),
        .irq       (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numAsserts++;
        assert (observed === expected)
        else begin
            numFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] alarm, input logic ready, input logic clr);
        alarm_in  = alarm;
        evt_ready = ready;
        ovf_clr   = clr;
    endtask

    task automatic nextCycle();
        @(negedge clk_1x);
    endtask

    initial begin
        reset     = 1'b1;
        mask_wr   = 1'b0;
        mask_data = '0;
        applyStimulus(24'h0, 1'b0, 1'b0);
        repeat (2) nextCycle();
        reset = 1'b0;

        checkOutput("rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_count", 32'(evt_count), 32'd0);
        checkOutput("rst_id", 32'(evt_id), 32'd0);
        checkOutput("rst_ts", 32'(evt_ts), 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);

        // Two-cycle level on alarm 5 gives exactly one event, visible after two edges.
        applyStimulus(24'h000020, 1'b0, 1'b0);
        nextCycle();
        checkOutput("lat1_valid", 32'(evt_valid), 32'd0);
        nextCycle();
        checkOutput("lat2_valid", 32'(evt_valid), 32'd1);
        checkOutput("lat2_id", 32'(evt_id), 32'd5);
        checkOutput("lat2_count", 32'(evt_count), 32'd1);
        applyStimulus(24'h0, 1'b0, 1'b0);
        repeat (3) nextCycle();
        checkOutput("single_count", 32'(evt_count), 32'd1);
        checkOutput("single_irq", 32'(irq), 32'd1);
        applyStimulus(24'h0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("pop1_valid", 32'(evt_valid), 32'd0);
        checkOutput("pop1_count", 32'(evt_count), 32'd0);

        // Simultaneous rises drain in index order with consecutive timestamps.
        applyStimulus(24'h020208, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("prio_id0", 32'(evt_id), 32'd3);
        checkOutput("prio_cnt0", 32'(evt_count), 32'd1);
        ts0 = evt_ts;
        applyStimulus(24'h0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("prio_id1", 32'(evt_id), 32'd9);
        checkOutput("prio_ts1", 32'(evt_ts), 32'(16'(ts0 + 16'd1)));
        nextCycle();
        checkOutput("prio_id2", 32'(evt_id), 32'd17);
        checkOutput("prio_ts2", 32'(evt_ts), 32'(16'(ts0 + 16'd2)));
        nextCycle();
        checkOutput("prio_empty", 32'(evt_valid), 32'd0);
        applyStimulus(24'h0, 1'b0, 1'b0);

        // Masked alarm 5 is ignored and stays gone after unmasking.
        mask_wr   = 1'b1;
        mask_data = 24'h000020;
        nextCycle();
        mask_wr = 1'b0;
        applyStimulus(24'h000060, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("mask_valid", 32'(evt_valid), 32'd1);
        checkOutput("mask_id", 32'(evt_id), 32'd6);
        checkOutput("mask_count", 32'(evt_count), 32'd1);
        applyStimulus(24'h0, 1'b0, 1'b0);
        mask_wr   = 1'b1;
        mask_data = 24'h0;
        nextCycle();
        mask_wr = 1'b0;
        repeat (2) nextCycle();
        checkOutput("unmask_count", 32'(evt_count), 32'd1);
        applyStimulus(24'h0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("unmask_empty", 32'(evt_count), 32'd0);
        applyStimulus(24'h0, 1'b0, 1'b0);

        // Nine alarms against an eight-deep FIFO, then a repeat rise on the waiting one.
        applyStimulus(24'h0001FF, 1'b0, 1'b0);
        repeat (2) nextCycle();
        applyStimulus(24'h0, 1'b0, 1'b0);
        repeat (10) nextCycle();
        checkOutput("full_count", 32'(evt_count), 32'd8);
        checkOutput("full_head", 32'(evt_id), 32'd0);
        checkOutput("full_ovf", 32'(overflow), 32'd0);
        applyStimulus(24'h000100, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(24'h0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("loss_ovf", 32'(overflow), 32'd1);
        checkOutput("loss_irq", 32'(irq), 32'd1);
        checkOutput("loss_count", 32'(evt_count), 32'd8);
        applyStimulus(24'h0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("reuse_count", 32'(evt_count), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("drain_id%0d", k), 32'(evt_id), 32'(k));
            nextCycle();
        end
        checkOutput("drain_empty", 32'(evt_valid), 32'd0);
        applyStimulus(24'h0, 1'b0, 1'b0);

        // A loss in the same cycle as ovf_clr keeps the flag; the next clear wins.
        applyStimulus(24'h0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("clr_ovf", 32'(overflow), 32'd0);
        checkOutput("clr_irq", 32'(irq), 32'd0);
        applyStimulus(24'h000007, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(24'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(24'h000004, 1'b0, 1'b1);
        nextCycle();
        checkOutput("setwins_ovf", 32'(overflow), 32'd1);
        applyStimulus(24'h0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("clr2_ovf", 32'(overflow), 32'd0);
        checkOutput("clr2_count", 32'(evt_count), 32'd3);
        checkOutput("clr2_head", 32'(evt_id), 32'd0);

        // Asynchronous reset mid-cycle with alarm 2 held high across release.
        applyStimulus(24'h000004, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(evt_valid), 32'd0);
        checkOutput("arst_count", 32'(evt_count), 32'd0);
        checkOutput("arst_irq", 32'(irq), 32'd0);
        repeat (2) nextCycle();
        reset = 1'b0;
        nextCycle();
        checkOutput("rel_lat1", 32'(evt_valid), 32'd0);
        nextCycle();
        checkOutput("rel_valid", 32'(evt_valid), 32'd1);
        checkOutput("rel_id", 32'(evt_id), 32'd2);
        checkOutput("rel_count", 32'(evt_count), 32'd1);
        repeat (3) nextCycle();
        checkOutput("rel_single", 32'(evt_count), 32'd1);
        applyStimulus(24'h0, 1'b0, 1'b0);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule
